// File: rtl/bram_self_test_pkg.sv
// Shared types and helpers for the BRAM self-test master.
// The optional per-transaction watchdog is enabled with BRAM_SELF_TEST_TIMEOUT_EN.
package bram_self_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_REQ = 3'd1,
        ST_WR_GAP = 3'd2,
        ST_RD_REQ = 3'd3,
        ST_RD_GAP = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam logic [3:0] WSTRB_WRITE = 4'b1111;
    localparam logic [3:0] WSTRB_READ  = 4'b0000;

    // Test pattern for word idx: seed XOR {idx, ~idx}
    function automatic logic [31:0] pattern_word(input logic [31:0] seed,
                                                 input logic [15:0] idx);
        return seed ^ {idx, ~idx};
    endfunction

endpackage

// File: rtl/bram_req_port.sv
// Request port toward the BRAM controller: owns the registered valid/addr/
// wdata/wstrb, reports the ready handshake and drops valid right after it,
// which produces the idle gap cycle. With BRAM_SELF_TEST_TIMEOUT_EN defined
// it also runs a watchdog on each outstanding request.
module bram_req_port #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        issue,
    input  logic [31:0] issue_addr,
    input  logic [31:0] issue_wdata,
    input  logic [3:0]  issue_wstrb,
    output logic        ack,
    output logic        tmo,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb
);

    logic        valid_q, valid_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    // ready is only meaningful while a request is outstanding
    assign ack = valid_q & mem_ready;

`ifdef BRAM_SELF_TEST_TIMEOUT_EN
    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] wdog_q, wdog_d;
    logic        tmo_s;

    // Count stalled cycles of the current request; fire on the last allowed one
    always_comb begin
        wdog_d = wdog_q;
        tmo_s  = 1'b0;
        if (issue) begin
            wdog_d = 32'd0;
        end else if (valid_q && !mem_ready) begin
            if (wdog_q == WDOG_LAST) begin
                tmo_s = 1'b1;
            end else begin
                wdog_d = wdog_q + 32'd1;
            end
        end else begin
            wdog_d = wdog_q;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_q <= 32'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign tmo = tmo_s;
`else
    assign tmo = 1'b0;
`endif

    // Load a new request, or retire it on handshake / watchdog expiry
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        if (issue) begin
            valid_d = 1'b1;
            addr_d  = issue_addr;
            wdata_d = issue_wdata;
            wstrb_d = issue_wstrb;
        end else if (ack || tmo) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Request registers; an in-flight request is abandoned on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'b0000;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign mem_valid = valid_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

endmodule

// File: rtl/bram_self_test.sv
// BRAM self-test master: on start, writes a seeded pattern to N_WORDS words,
// reads them back and reports error count / first failing address.
// Optional watchdog: define BRAM_SELF_TEST_TIMEOUT_EN.
module bram_self_test
    import bram_self_test_pkg::*;
#(
    parameter int          N_WORDS        = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [31:0] SEED           = 32'hA5A5_5A5A,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [31:0] first_err_addr,
    output logic        timeout,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    localparam logic [15:0] LAST_IDX = 16'(N_WORDS - 1);

    state_e      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [31:0] first_err_q, first_err_d;

    logic        issue_s;
    logic        issue_rd_s;
    logic [15:0] issue_idx_s;
    logic [31:0] issue_addr_s;
    logic [31:0] issue_wdata_s;
    logic [3:0]  issue_wstrb_s;
    logic        ack_s;
    logic        tmo_s;
    logic [31:0] cur_addr_s;
    logic [15:0] err_inc_s;

    assign cur_addr_s    = BASE_ADDR + {14'd0, idx_q, 2'b00};
    assign err_inc_s     = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
    assign issue_addr_s  = BASE_ADDR + {14'd0, issue_idx_s, 2'b00};
    assign issue_wdata_s = issue_rd_s ? 32'd0 : pattern_word(SEED, issue_idx_s);
    assign issue_wstrb_s = issue_rd_s ? WSTRB_READ : WSTRB_WRITE;

    // Sequencer: next state, index, result flags and the next request to issue
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        issue_s     = 1'b0;
        issue_rd_s  = 1'b0;
        issue_idx_s = idx_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_cnt_d   = 16'd0;
                    first_err_d = 32'd0;
                    timeout_d   = 1'b0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    idx_d       = 16'd0;
                    issue_s     = 1'b1;
                    issue_idx_s = 16'd0;
                    state_d     = ST_WR_REQ;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WR_REQ, ST_RD_REQ: begin
                if (tmo_s) begin
                    // Stalled slave: record it as an error and finish early
                    timeout_d = 1'b1;
                    err_cnt_d = err_inc_s;
                    if (err_cnt_q == 16'd0) begin
                        first_err_d = cur_addr_s;
                    end else begin
                        first_err_d = first_err_q;
                    end
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (ack_s) begin
                    if (state_q == ST_RD_REQ) begin
                        if (mem_rdata != pattern_word(SEED, idx_q)) begin
                            err_cnt_d = err_inc_s;
                            if (err_cnt_q == 16'd0) begin
                                first_err_d = cur_addr_s;
                            end else begin
                                first_err_d = first_err_q;
                            end
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                        state_d = ST_RD_GAP;
                    end else begin
                        state_d = ST_WR_GAP;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_WR_GAP: begin
                issue_s = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d       = 16'd0;
                    issue_idx_s = 16'd0;
                    issue_rd_s  = 1'b1;
                    state_d     = ST_RD_REQ;
                end else begin
                    idx_d       = idx_q + 16'd1;
                    issue_idx_s = idx_q + 16'd1;
                    state_d     = ST_WR_REQ;
                end
            end
            ST_RD_GAP: begin
                if (idx_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_q == 16'd0) && !timeout_q;
                    state_d = ST_DONE;
                end else begin
                    issue_s     = 1'b1;
                    issue_rd_s  = 1'b1;
                    idx_d       = idx_q + 16'd1;
                    issue_idx_s = idx_q + 16'd1;
                    state_d     = ST_RD_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 16'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_cnt_q   <= 16'd0;
            first_err_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
        end
    end

    bram_req_port #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_req_port (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue       (issue_s),
        .issue_addr  (issue_addr_s),
        .issue_wdata (issue_wdata_s),
        .issue_wstrb (issue_wstrb_s),
        .ack         (ack_s),
        .tmo         (tmo_s),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_cnt_q;
    assign first_err_addr = first_err_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_bram_self_test.sv
// Testbench for bram_self_test: behavioural BRAM slave with optional read
// corruption, transaction monitor and a reference model of the expected
// transaction sequence and results. Timeout scenario runs only when
// BRAM_SELF_TEST_TIMEOUT_EN is defined.
module tb_bram_self_test;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] SEED = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int n_assert = 0;
    int n_fail   = 0;

    // slave control and storage
    logic [31:0] smem    [0:63];
    logic [31:0] corrupt [0:N-1];
    bit          hang     = 1'b0;
    bit          rand_lat = 1'b0;
    int          fixed_lat = 3;
    int          cur_lat   = 3;
    int          lat_cnt   = 0;

    // monitor state
    logic [31:0] log_a [$];
    logic [31:0] log_d [$];
    logic [3:0]  log_s [$];
    int          gap_viol = 0;
    int          valid_hi = 0;
    bit          prev_hs  = 1'b0;

    bram_self_test #(
        .N_WORDS        (N),
        .BASE_ADDR      (BASE),
        .SEED           (SEED),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .timeout        (timeout),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    // expected data word: upper half = index, lower half = 65535 - index
    function automatic logic [31:0] ref_pat(input int i);
        int lo;
        lo = i % 65536;
        return SEED ^ 32'((lo * 65536) + (65535 - lo));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // BRAM slave: answers after cur_lat cycles of valid, one-cycle ready pulse
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        for (int k = 0; k < 64; k++) smem[k] = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n || mem_ready) begin
                mem_ready = 1'b0;
                lat_cnt   = 0;
            end else if (mem_valid && !hang) begin
                lat_cnt++;
                if (lat_cnt >= cur_lat) begin
                    int w;
                    w = int'((mem_addr - BASE) >> 2) % 64;
                    mem_ready = 1'b1;
                    lat_cnt   = 0;
                    if (mem_wstrb == 4'b1111) smem[w] = mem_wdata;
                    else mem_rdata = smem[w] ^ ((w < N) ? corrupt[w] : 32'd0);
                    cur_lat = rand_lat ? int'($urandom_range(1, 4)) : fixed_lat;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Monitor: log handshakes, detect missing idle gap, count valid cycles
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_hs = 1'b0;
            end else begin
                if (mem_valid) valid_hi++;
                if (mem_valid && prev_hs) gap_viol++;
                prev_hs = mem_valid && mem_ready;
                if (mem_valid && mem_ready) begin
                    log_a.push_back(mem_addr);
                    log_d.push_back(mem_wdata);
                    log_s.push_back(mem_wstrb);
                end
            end
        end
    end

    // One full test run against the reference model; poke>0 re-pulses start mid-run
    task automatic run_test(input string tag, input int lat, input bit rnd, input int poke);
        int          cyc;
        int          exp_err;
        logic [31:0] exp_first;
        int          nlog;
        log_a.delete();
        log_d.delete();
        log_s.delete();
        gap_viol  = 0;
        fixed_lat = lat;
        rand_lat  = rnd;
        cur_lat   = rnd ? int'($urandom_range(1, 4)) : lat;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ":busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, ":done_cleared"}, 32'(done), 32'd0);
        chk({tag, ":err_cleared"}, 32'(err_count), 32'd0);
        chk({tag, ":first_cleared"}, first_err_addr, 32'd0);
        cyc = 0;
        while (!done && cyc < 4000) begin
            if (poke != 0 && cyc == poke) start = 1'b1;
            tick();
            start = 1'b0;
            cyc++;
        end
        chk({tag, ":done"}, 32'(done), 32'd1);
        chk({tag, ":busy_end"}, 32'(busy), 32'd0);
        exp_err   = 0;
        exp_first = 32'd0;
        for (int i = 0; i < N; i++) begin
            if (corrupt[i] != 32'd0) begin
                if (exp_err == 0) exp_first = BASE + 32'(4 * i);
                exp_err++;
            end
        end
        chk({tag, ":err_count"}, 32'(err_count), 32'(exp_err));
        chk({tag, ":first_err"}, first_err_addr, exp_first);
        chk({tag, ":pass"}, 32'(pass), (exp_err == 0) ? 32'd1 : 32'd0);
        chk({tag, ":timeout"}, 32'(timeout), 32'd0);
        chk({tag, ":gap"}, 32'(gap_viol), 32'd0);
        nlog = log_a.size();
        chk({tag, ":n_xfer"}, 32'(nlog), 32'(2 * N));
        for (int k = 0; k < 2 * N && k < nlog; k++) begin
            bit rd;
            rd = (k >= N);
            chk({tag, ":addr"}, log_a[k], BASE + 32'(4 * (k % N)));
            chk({tag, ":wdata"}, log_d[k], rd ? 32'd0 : ref_pat(k % N));
            chk({tag, ":wstrb"}, 32'(log_s[k]), rd ? 32'd0 : 32'hF);
        end
    endtask

    task automatic clear_corrupt();
        for (int i = 0; i < N; i++) corrupt[i] = 32'd0;
    endtask

    initial begin
        int cyc;
        clear_corrupt();
        reset_n = 1'b0;
        start   = 1'b0;
        tick();
        tick();
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:done", 32'(done), 32'd0);
        chk("rst:pass", 32'(pass), 32'd0);
        chk("rst:timeout", 32'(timeout), 32'd0);
        chk("rst:err", 32'(err_count), 32'd0);
        chk("rst:first", first_err_addr, 32'd0);
        chk("rst:valid", 32'(mem_valid), 32'd0);
        chk("rst:addr", mem_addr, 32'd0);
        chk("rst:wdata", mem_wdata, 32'd0);
        chk("rst:wstrb", 32'(mem_wstrb), 32'd0);
        reset_n = 1'b1;
        tick();
        tick();
        chk("idle:busy", 32'(busy), 32'd0);

        // clean pass with 3-cycle slave
        run_test("clean", 3, 1'b0, 0);
        chk("clean:word1_wdata", (log_d.size() > 1) ? log_d[1] : 32'd0, 32'hA5A4_A5A4);

        // single corrupted read; the following run also checks clearing from DONE
        corrupt[2] = 32'h0000_0001;
        run_test("bad2", 3, 1'b0, 0);
        clear_corrupt();
        corrupt[1] = 32'h0000_0001;
        corrupt[3] = 32'h0000_0001;
        run_test("bad13", 3, 1'b0, 0);
        clear_corrupt();

        // start re-pulsed while busy must not disturb the sequence
        run_test("poke", 3, 1'b0, 20);

        // asynchronous reset during the read of word 2
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!(mem_valid && mem_wstrb == 4'b0000 && mem_addr == BASE + 32'd8) && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("midrst:reached_rd2", 32'(mem_valid && mem_wstrb == 4'b0000), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst:valid", 32'(mem_valid), 32'd0);
        chk("midrst:busy", 32'(busy), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("midrst:done", 32'(done), 32'd0);
        run_test("after_rst", 3, 1'b0, 0);

        // randomized corruption and slave latency
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++)
                corrupt[i] = ($urandom_range(0, 1) == 1) ? ($urandom | 32'h1) : 32'd0;
            run_test("rand", 1, 1'b1, 0);
        end
        clear_corrupt();

`ifdef BRAM_SELF_TEST_TIMEOUT_EN
        // slave never answers the first write
        hang = 1'b1;
        fixed_lat = 3;
        rand_lat  = 1'b0;
        valid_hi  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("tmo:done", 32'(done), 32'd1);
        chk("tmo:timeout", 32'(timeout), 32'd1);
        chk("tmo:pass", 32'(pass), 32'd0);
        chk("tmo:err", 32'(err_count), 32'd1);
        chk("tmo:first", first_err_addr, 32'd0);
        chk("tmo:valid_cycles", 32'(valid_hi), 32'd8);
        chk("tmo:valid_low", 32'(mem_valid), 32'd0);
        hang = 1'b0;
        run_test("tmo_recover", 2, 1'b0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
